multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over several clock cycles. It drives the datapath muxes, the register-file, IR and PC write enables, the memory request strobes, and the 2-bit `alu_op` consumed by the ALU control decoder. It sits between the instruction register and the shared datapath, and stalls on a memory ready handshake.

---
 rtl/riscv_pkg.sv | 57 +++++
 rtl/ctrl_out_decode.sv | 123 ++++++++++++
 rtl/multicycle_ctrl.sv | 75 +++++++
 tb/tb_multicycle_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// opcodes, ALU operation codes and datapath mux-select encodings.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BEQ     = 4'd9,
        S_JAL     = 4'd10,
        S_ILLEGAL = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALUOUT  = 1'b1;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Successor of DECODE for a given opcode; unknown opcodes trap.
    function automatic state_e decode_next(input logic [6:0] op);
        state_e nxt;
        case (op)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_R:              nxt = S_EXECR;
            OP_I:              nxt = S_EXECI;
            OP_BRANCH:         nxt = S_BEQ;
            OP_JAL:            nxt = S_JAL;
            default:           nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational output decode of the multicycle control FSM. All outputs are
// forced to zero while `active` (tied to rst_n) is low.
module ctrl_out_decode
    import riscv_pkg::*;
(
    input  state_e      state,
    input  logic        zero,
    input  logic        mem_ready,
    input  logic        active,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal_instr
);

    logic       pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;
    logic       adr_src_s, instr_done_s, illegal_s;
    logic [1:0] src_a_s, src_b_s, result_src_s, alu_op_s;

    // Per-state output table; only BEQ's pc_write and the ready-dependent
    // strobes look past the state register.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = ADR_PC;
        src_a_s      = SRCA_PC;
        src_b_s      = SRCB_RS2;
        result_src_s = RES_ALUOUT;
        alu_op_s     = ALUOP_ADD;
        instr_done_s = 1'b0;
        illegal_s    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_s = 1'b1;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    src_b_s      = SRCB_FOUR;
                    result_src_s = RES_ALU;
                end else begin
                    ir_write_s   = 1'b0;
                end
            end
            S_DECODE: begin
                src_a_s = SRCA_OLDPC;
                src_b_s = SRCB_IMM;
            end
            S_MEMADR: begin
                src_a_s = SRCA_RS1;
                src_b_s = SRCB_IMM;
            end
            S_MEMRD: begin
                adr_src_s  = ADR_ALUOUT;
                mem_read_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = RES_MEM;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                adr_src_s    = ADR_ALUOUT;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready;
            end
            S_EXECR: begin
                src_a_s  = SRCA_RS1;
                alu_op_s = ALUOP_FUNCT;
            end
            S_EXECI: begin
                src_a_s  = SRCA_RS1;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BEQ: begin
                src_a_s      = SRCA_RS1;
                alu_op_s     = ALUOP_SUB;
                pc_write_s   = zero;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                src_a_s    = SRCA_OLDPC;
                src_b_s    = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    assign pc_write      = pc_write_s   & active;
    assign ir_write      = ir_write_s   & active;
    assign reg_write     = reg_write_s  & active;
    assign mem_read      = mem_read_s   & active;
    assign mem_write     = mem_write_s  & active;
    assign adr_src       = adr_src_s    & active;
    assign instr_done    = instr_done_s & active;
    assign illegal_instr = illegal_s    & active;
    assign alu_src_a     = active ? src_a_s      : 2'b00;
    assign alu_src_b     = active ? src_b_s      : 2'b00;
    assign result_src    = active ? result_src_s : 2'b00;
    assign alu_op        = active ? alu_op_s     : 2'b00;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: state register and
// next-state logic; output decode lives in ctrl_out_decode.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal_instr
);

    state_e state_q, state_d;

    // Next-state logic; memory states stall until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = decode_next(opcode);
            S_MEMADR:  state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            S_JAL:     state_d = S_ALUWB;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    ctrl_out_decode u_out (
        .state         (state_q),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .active        (rst_n),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process expands each
// instruction into its expected per-cycle control word; a monitor compares.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero, mem_ready;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
    logic        instr_done, illegal_instr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [16:0] v;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .instr_done(instr_done),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    wire [16:0] got = {pc_write, ir_write, reg_write, mem_read, mem_write,
                       adr_src, alu_src_a, alu_src_b, result_src, alu_op,
                       instr_done, illegal_instr};

    // Control word in the same field order as `got`.
    function automatic logic [16:0] mk(input logic pcw, input logic irw,
        input logic rw, input logic mr, input logic mw, input logic adr,
        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
        input logic [1:0] aop, input logic done, input logic ill);
        return {pcw, irw, rw, mr, mw, adr, sa, sb, rs, aop, done, ill};
    endfunction

    // Monitor: one expected word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (got !== e.v) begin
                fails++;
                $display("FAIL %s: got %b expected %b at %0t", e.tag, got, e.v, $time);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    task automatic cyc(input logic [16:0] e, input string tag, input logic rdy,
                       input logic z, input logic [6:0] op, input logic r);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; mem_ready = rdy; zero = z; opcode = op;
        x.v = e; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic g, input logic e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, g, e);
        end
    endtask

    task automatic fetch(input int fw);
        for (int i = 0; i < fw; i++)
            cyc(mk(0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0), "fetch_wait", 1'b0, rb(), rop(), 1'b1);
        cyc(mk(1,1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0), "fetch_ready", 1'b1, rb(), rop(), 1'b1);
    endtask

    task automatic aluwb();
        cyc(mk(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0), "aluwb", rb(), rb(), rop(), 1'b1);
    endtask

    // One whole instruction: fw/mw are wait cycles in FETCH and MEMRD/MEMWR.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
        fetch(fw);
        cyc(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0), "decode", rb(), rb(), op, 1'b1);
        case (op)
            T_LOAD, T_STORE: begin
                cyc(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0), "memadr", rb(), rb(), op, 1'b1);
                if (op == T_LOAD) begin
                    for (int i = 0; i < mw; i++)
                        cyc(mk(0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0), "memrd_wait", 1'b0, rb(), rop(), 1'b1);
                    cyc(mk(0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0), "memrd_ready", 1'b1, rb(), rop(), 1'b1);
                    cyc(mk(0,0,1,0,0,0, 2'b00,2'b00,2'b01,2'b00, 1,0), "memwb", rb(), rb(), rop(), 1'b1);
                end else begin
                    for (int i = 0; i < mw; i++)
                        cyc(mk(0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 0,0), "memwr_wait", 1'b0, rb(), rop(), 1'b1);
                    cyc(mk(0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 1,0), "memwr_ready", 1'b1, rb(), rop(), 1'b1);
                end
            end
            T_R: begin
                cyc(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 0,0), "execr", rb(), rb(), rop(), 1'b1);
                aluwb();
            end
            T_I: begin
                cyc(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10, 0,0), "execi", rb(), rb(), rop(), 1'b1);
                aluwb();
            end
            T_BRANCH: begin
                cyc(mk(z,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 1,0), "beq", rb(), z, rop(), 1'b1);
            end
            T_JAL: begin
                cyc(mk(1,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0), "jal", rb(), rb(), rop(), 1'b1);
                aluwb();
            end
            default: begin
                for (int i = 0; i < 20; i++)
                    cyc(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1), "illegal", rb(), rb(), rop(), 1'b1);
            end
        endcase
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(17'd0, "reset", rb(), rb(), rop(), 1'b0);
    endtask

    initial begin
        logic [6:0] kinds [6];
        exp_t x;
        kinds[0] = T_LOAD; kinds[1] = T_STORE; kinds[2] = T_R;
        kinds[3] = T_I;    kinds[4] = T_BRANCH; kinds[5] = T_JAL;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 7'd0;

        reset_cycles(3);
        run_instr(T_I, 0, 0, 1'b0);
        run_instr(T_LOAD, 2, 2, 1'b0);
        run_instr(T_BRANCH, 0, 0, 1'b1);
        run_instr(T_BRANCH, 0, 0, 1'b0);
        run_instr(T_JAL, 0, 0, 1'b0);
        run_instr(T_STORE, 1, 1, 1'b0);
        run_instr(T_R, 0, 0, 1'b0);

        // Reset dropped while MEMWR is requesting the write.
        fetch(0);
        cyc(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0), "decode", 1'b0, 1'b0, T_STORE, 1'b1);
        cyc(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0), "memadr", 1'b0, 1'b0, T_STORE, 1'b1);
        cyc(mk(0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 0,0), "memwr_wait", 1'b0, 1'b0, rop(), 1'b1);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        #1 chk("memwr_before_reset", mem_write, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("memwr_async_drop", mem_write, 1'b0);
        x.v = 17'd0; x.tag = "reset_mid_memwr";
        exp_q.push_back(x);
        reset_cycles(2);
        run_instr(T_I, 0, 0, 1'b0);

        // Illegal opcode traps until reset.
        run_instr(T_BAD, 0, 0, 1'b0);
        reset_cycles(2);
        run_instr(T_R, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++)
            run_instr(kinds[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), rb());

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
